// File: rtl/cache_ctrl_param_pkg.sv
// Shared definitions for the parametrised cache controller: FSM states and policy encodings.
package cache_ctrl_param_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_WB,
        ST_FILL,
        ST_WT
    } state_e;

    localparam bit POLICY_WB = 1'b0;
    localparam bit POLICY_WT = 1'b1;

endpackage

// File: rtl/cache_ctrl_param_way_array.sv
// One cache way: per-set valid/dirty/tag/data storage, combinational read, single write port.
module cache_ctrl_param_way_array #(
    parameter int SETS       = 4,
    parameter int IDX_W      = 2,
    parameter int TAG_W      = 6,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [IDX_W-1:0]      idx,
    output logic                  rd_valid,
    output logic                  rd_dirty,
    output logic [TAG_W-1:0]      rd_tag,
    output logic [DATA_WIDTH-1:0] rd_data,
    input  logic                  wr_en,
    input  logic [TAG_W-1:0]      wr_tag,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_valid,
    input  logic                  wr_dirty
);

    logic [SETS-1:0]                 valid_q, valid_d, dirty_q, dirty_d;
    logic [SETS-1:0][TAG_W-1:0]      tag_q, tag_d;
    logic [SETS-1:0][DATA_WIDTH-1:0] data_q, data_d;

    always_comb begin
        valid_d = valid_q;
        dirty_d = dirty_q;
        tag_d   = tag_q;
        data_d  = data_q;
        if (wr_en) begin
            valid_d[idx] = wr_valid;
            dirty_d[idx] = wr_dirty;
            tag_d[idx]   = wr_tag;
            data_d[idx]  = wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            valid_q <= valid_d;
            dirty_q <= dirty_d;
        end
    end

    // Tag and data contents are meaningless while valid is clear, so they carry no reset.
    always_ff @(posedge clk) begin
        tag_q  <= tag_d;
        data_q <= data_d;
    end

    assign rd_valid = valid_q[idx];
    assign rd_dirty = dirty_q[idx];
    assign rd_tag   = tag_q[idx];
    assign rd_data  = data_q[idx];

endmodule

// File: rtl/cache_ctrl_param.sv
// N-set, 1/2-way cache controller with LRU replacement and write-back or write-through policy.
module cache_ctrl_param
    import cache_ctrl_param_pkg::*;
#(
    parameter int ADDR_WIDTH    = 8,
    parameter int DATA_WIDTH    = 8,
    parameter int SETS          = 4,
    parameter int WAYS          = 2,
    parameter bit WRITE_THROUGH = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic                  read_operation,
    output logic                  cache_busy,
    output logic [DATA_WIDTH-1:0] read_data,
    output logic                  read_valid,
    output logic                  hit,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_ack
);

    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = ADDR_WIDTH - IDX_W;
    localparam bit IS_WT = (WRITE_THROUGH == POLICY_WT);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d, mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d, read_data_q, read_data_d, mem_wdata_q, mem_wdata_d;
    logic                  rd_op_q, rd_op_d, busy_q, busy_d, read_valid_q, read_valid_d;
    logic                  hit_q, hit_d, mem_req_q, mem_req_d, mem_we_q, mem_we_d;
    logic                  was_hit_q, was_hit_d, victim_q, victim_d;
    logic [SETS-1:0]       lru_q, lru_d;

    logic [1:0]                 way_valid, way_dirty, way_we, hit_vec;
    logic [1:0][TAG_W-1:0]      way_tag;
    logic [1:0][DATA_WIDTH-1:0] way_data;
    logic [DATA_WIDTH-1:0]      wr_data;
    logic                       wr_dirty, hit_way, victim_c, go_wt;
    logic [IDX_W-1:0]           idx;
    logic [TAG_W-1:0]           tag;

    assign idx = addr_q[IDX_W-1:0];
    assign tag = addr_q[ADDR_WIDTH-1:IDX_W];

    // Way slot 1 is tied off as permanently invalid in a direct-mapped build.
    for (genvar w = 0; w < 2; w++) begin : g_way
        if (w < WAYS) begin : g_inst
            cache_ctrl_param_way_array #(
                .SETS(SETS), .IDX_W(IDX_W), .TAG_W(TAG_W), .DATA_WIDTH(DATA_WIDTH)
            ) u_way (
                .clk(clk), .rst(rst), .idx(idx),
                .rd_valid(way_valid[w]), .rd_dirty(way_dirty[w]),
                .rd_tag(way_tag[w]), .rd_data(way_data[w]),
                .wr_en(way_we[w]), .wr_tag(tag), .wr_data(wr_data),
                .wr_valid(1'b1), .wr_dirty(wr_dirty)
            );
        end else begin : g_tie
            assign way_valid[w] = 1'b0;
            assign way_dirty[w] = 1'b0;
            assign way_tag[w]   = '0;
            assign way_data[w]  = '0;
        end
        assign hit_vec[w] = way_valid[w] && (way_tag[w] == tag);
    end

    assign hit_way  = ~hit_vec[0];
    assign victim_c = (WAYS == 1)    ? 1'b0 :
                      !way_valid[0]  ? 1'b0 :
                      !way_valid[1]  ? 1'b1 : lru_q[idx];

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rd_op_d      = rd_op_q;
        busy_d       = busy_q;
        read_data_d  = read_data_q;
        read_valid_d = 1'b0;
        hit_d        = hit_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        was_hit_d    = was_hit_q;
        victim_d     = victim_q;
        lru_d        = lru_q;
        way_we       = '0;
        wr_data      = wdata_q;
        wr_dirty     = 1'b0;
        go_wt        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    addr_d  = address;
                    wdata_d = write_data;
                    rd_op_d = read_operation;
                    busy_d  = 1'b1;
                    state_d = ST_LOOKUP;
                end
            end
            ST_LOOKUP: begin
                if (|hit_vec) begin
                    if (WAYS == 2) lru_d[idx] = ~hit_way;
                    if (rd_op_q) begin
                        read_data_d  = way_data[hit_way];
                        read_valid_d = 1'b1;
                        hit_d        = 1'b1;
                        busy_d       = 1'b0;
                        state_d      = ST_IDLE;
                    end else begin
                        way_we[hit_way] = 1'b1;
                        wr_dirty        = !IS_WT;
                        was_hit_d       = 1'b1;
                        if (IS_WT) begin
                            go_wt = 1'b1;
                        end else begin
                            hit_d   = 1'b1;
                            busy_d  = 1'b0;
                            state_d = ST_IDLE;
                        end
                    end
                end else begin
                    victim_d  = victim_c;
                    was_hit_d = 1'b0;
                    if (IS_WT && !rd_op_q) begin
                        go_wt = 1'b1;
                    end else if (!IS_WT && way_valid[victim_c] && way_dirty[victim_c]) begin
                        state_d     = ST_WB;
                        mem_req_d   = 1'b1;
                        mem_we_d    = 1'b1;
                        mem_addr_d  = {way_tag[victim_c], idx};
                        mem_wdata_d = way_data[victim_c];
                    end else begin
                        state_d    = ST_FILL;
                        mem_req_d  = 1'b1;
                        mem_we_d   = 1'b0;
                        mem_addr_d = addr_q;
                    end
                end
                if (go_wt) begin
                    state_d     = ST_WT;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b1;
                    mem_addr_d  = addr_q;
                    mem_wdata_d = wdata_q;
                end
            end
            ST_WB: begin
                if (mem_ack) begin
                    mem_req_d = 1'b0;
                    state_d   = ST_FILL;
                end
            end
            ST_FILL: begin
                // Arriving from WB the request is low for one cycle before the line read goes out.
                if (!mem_req_q) begin
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = addr_q;
                end else if (mem_ack) begin
                    way_we[victim_q] = 1'b1;
                    if (rd_op_q) begin
                        wr_data      = mem_rdata;
                        read_data_d  = mem_rdata;
                        read_valid_d = 1'b1;
                    end else begin
                        wr_dirty = 1'b1;
                    end
                    if (WAYS == 2) lru_d[idx] = ~victim_q;
                    mem_req_d = 1'b0;
                    hit_d     = 1'b0;
                    busy_d    = 1'b0;
                    state_d   = ST_IDLE;
                end
            end
            ST_WT: begin
                if (mem_ack) begin
                    mem_req_d = 1'b0;
                    hit_d     = was_hit_q;
                    busy_d    = 1'b0;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            addr_q       <= '0;
            wdata_q      <= '0;
            rd_op_q      <= 1'b0;
            busy_q       <= 1'b0;
            read_data_q  <= '0;
            read_valid_q <= 1'b0;
            hit_q        <= 1'b0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            was_hit_q    <= 1'b0;
            victim_q     <= 1'b0;
            lru_q        <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rd_op_q      <= rd_op_d;
            busy_q       <= busy_d;
            read_data_q  <= read_data_d;
            read_valid_q <= read_valid_d;
            hit_q        <= hit_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            was_hit_q    <= was_hit_d;
            victim_q     <= victim_d;
            lru_q        <= lru_d;
        end
    end

    assign cache_busy = busy_q;
    assign read_data  = read_data_q;
    assign read_valid = read_valid_q;
    assign hit        = hit_q;
    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;

endmodule
